// File: rtl/sobel_window_ctrl.sv
// Streaming 5x5 window controller for a Sobel datapath: four line buffers feed a
// shifting window; window-valid strobes are delayed to line up with edge_in.
module sobel_window_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int LAT    = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  input  logic         pix_sof,
  output logic         pix_ready,
  output logic [199:0] matrix_out,
  input  logic [7:0]   edge_in,
  output logic [7:0]   edge_out,
  output logic         edge_valid,
  output logic         frame_done,
  output logic         busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, pcol;
  logic [RW-1:0] row_q, row_d, prow;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          pix_ready_q, busy_q;
  logic [7:0]    lb0 [WIDTH];
  logic [7:0]    lb1 [WIDTH];
  logic [7:0]    lb2 [WIDTH];
  logic [7:0]    lb3 [WIDTH];
  logic [7:0]    win_q [25];
  logic [7:0]    ncol [5];
  logic          win_valid_q, win_last_q;
  logic [LAT-1:0] vld_q, lst_q;
  logic          edge_valid_q, edge_last_q, frame_done_q;
  logic [7:0]    edge_out_q;
  logic          acc, take, resync, win_hit, last_px;

  // take: pixel enters the frame; non-sof pixels seen in IDLE are dropped
  assign acc     = pix_valid & pix_ready_q;
  assign take    = acc & (pix_sof | (state_q == PRIME) | (state_q == STREAM));
  assign resync  = acc & pix_sof & ((state_q == PRIME) | (state_q == STREAM));
  assign pcol    = pix_sof ? '0 : col_q;
  assign prow    = pix_sof ? '0 : row_q;
  assign last_px = (prow == ROW_LAST) & (pcol == COL_LAST);
  assign win_hit = take & ~pix_sof & (row_q >= RW'(4)) & (col_q >= CW'(4));

  always_comb begin
    ncol[0] = lb3[pcol];
    ncol[1] = lb2[pcol];
    ncol[2] = lb1[pcol];
    ncol[3] = lb0[pcol];
    ncol[4] = pix_in;
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    col_d   = col_q;
    row_d   = row_q;
    if (take) begin
      if (pcol == COL_LAST) begin
        col_d = '0;
        row_d = (prow == ROW_LAST) ? '0 : prow + 1'b1;
      end else begin
        col_d = pcol + 1'b1;
        row_d = prow;
      end
    end
    unique case (state_q)
      IDLE:   if (take) state_d = PRIME;
      PRIME:  if (take && prow == RW'(4) && pcol == '0) state_d = STREAM;
      STREAM: if (take) begin
        if (pix_sof) state_d = PRIME;
        else if (last_px) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DRAIN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset && take) begin
      lb3[pcol] <= lb2[pcol];
      lb2[pcol] <= lb1[pcol];
      lb1[pcol] <= lb0[pcol];
      lb0[pcol] <= pix_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      dcnt_q       <= '0;
      for (int i = 0; i < 25; i++) win_q[i] <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      vld_q        <= '0;
      lst_q        <= '0;
      edge_valid_q <= 1'b0;
      edge_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      edge_out_q   <= 8'hff;
      busy_q       <= 1'b0;
      pix_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dcnt_q      <= dcnt_d;
      pix_ready_q <= (state_d != DRAIN);
      busy_q      <= (state_d != IDLE);
      if (take) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) win_q[r*5+c] <= win_q[r*5+c+1];
          win_q[r*5+4] <= ncol[r];
        end
      end
      win_valid_q <= win_hit;
      win_last_q  <= win_hit & last_px & (state_q == STREAM);
      // a resync kills every strobe belonging to the aborted frame
      if (resync) begin
        vld_q       <= '0;
        lst_q       <= '0;
        edge_last_q <= 1'b0;
      end else begin
        vld_q[0] <= win_valid_q;
        lst_q[0] <= win_last_q;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          lst_q[i] <= lst_q[i-1];
        end
        edge_last_q <= lst_q[LAT-1];
      end
      edge_valid_q <= vld_q[LAT-1] & ~resync;
      if (vld_q[LAT-1]) edge_out_q <= edge_in;
      frame_done_q <= edge_last_q & ~resync;
    end
  end

  for (genvar i = 0; i < 25; i++) begin : g_mat
    assign matrix_out[8*(24-i) +: 8] = win_q[i];
  end

  assign pix_ready  = pix_ready_q;
  assign busy       = busy_q;
  assign edge_out   = edge_out_q;
  assign edge_valid = edge_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl on an 8x6 frame with a 3-stage stand-in sobel;
// expected edges come from windows cut directly out of the frame image.
module tb_sobel_window_ctrl;
  localparam int W = 8, H = 6, L = 3, NPIX = 48, NEDGE = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         pix_sof = 1'b0;
  logic         pix_ready;
  logic [199:0] matrix_out;
  logic [7:0]   edge_in;
  logic [7:0]   edge_out;
  logic         edge_valid, frame_done, busy;

  always #5 clock = ~clock;

  sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .LAT(L)) dut (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .matrix_out(matrix_out),
    .edge_in(edge_in), .edge_out(edge_out), .edge_valid(edge_valid),
    .frame_done(frame_done), .busy(busy)
  );

  int checks = 0, failures = 0, cyc = 0;
  int img [H][W];
  int cont_img [H][W];
  logic [7:0] cont_vals [NEDGE];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int got_cyc [$];
  int fd_cnt = 0, fd_cyc = 0;
  logic [7:0] sp [L];

  function automatic logic [7:0] sob(input logic [199:0] m);
    int z [25];
    int gx, gy, s;
    for (int i = 0; i < 25; i++) z[i] = int'(m[8*(24-i) +: 8]);
    gx = (z[8] + 2*z[13] + z[18]) - (z[6] + 2*z[11] + z[16]);
    gy = (z[16] + 2*z[17] + z[18]) - (z[6] + 2*z[7] + z[8]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    for (int i = 0; i < 25; i++) s += z[i] * (i + 1);
    return 8'(s);
  endfunction

  // window whose bottom-right pixel is (r,c), taken straight from the image
  function automatic logic [199:0] win_of(input int r, input int c);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        m[8*(24-(i*5+j)) +: 8] = 8'(img[r-4+i][c-4+j]);
    return m;
  endfunction

  always @(posedge clock) begin
    sp[0] <= sob(matrix_out);
    for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
  end
  assign edge_in = sp[L-1];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (edge_valid === 1'b1) begin
      got_q.push_back(edge_out);
      got_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int r = 4; r < H; r++)
      for (int c = 4; c < W; c++) exp_q.push_back(sob(win_of(r, c)));
  endtask

  // entered and left at a negedge; pix_valid stays up for back-to-back pixels
  task automatic drive_px(input logic [7:0] v, input bit sof, input int gap, output int acc);
    int n, g;
    g = 0;
    while (g < 20 && int'($urandom_range(99)) < gap) begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      @(negedge clock);
      g++;
    end
    pix_in = v; pix_sof = sof; pix_valid = 1'b1; n = 0;
    while (pix_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout: pix_ready=%b required=1", pix_ready);
    end
    @(posedge clock);
    #1 acc = cyc;
    @(negedge clock);
  endtask

  task automatic drive_range(input int first, input int last, input int gap,
                             output int a36, output int alast);
    int a;
    a36 = -1; alast = -1;
    for (int idx = first; idx <= last; idx++) begin
      drive_px(8'(img[idx/W][idx%W]), idx == 0, gap, a);
      if (idx == 36) a36 = a;
      alast = a;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_in = 8'h5a;
    repeat (3) @(negedge clock);
    checks++; if (matrix_out !== 200'd0) begin failures++; $display("FAIL rst_matrix: got %h required 0", matrix_out); end
    checks++; if (edge_out !== 8'hff) begin failures++; $display("FAIL rst_edge_out: got %h required ff", edge_out); end
    checks++; if (edge_valid !== 1'b0) begin failures++; $display("FAIL rst_edge_valid: got %b required 0", edge_valid); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL rst_pix_ready: got %b required 0", pix_ready); end
    pix_valid = 1'b0; pix_sof = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b required 1", pix_ready); end
  endtask

  task automatic test_idle_discard();
    int a, b;
    b = got_q.size();
    for (int i = 0; i < 10; i++) begin
      drive_px(8'($urandom_range(255)), 1'b0, 0, a);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b required 0", busy); end
    end
    pix_valid = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (matrix_out !== 200'd0) begin failures++; $display("FAIL idle_matrix: got %h required 0", matrix_out); end
    checks++; if (got_q.size() != b) begin failures++; $display("FAIL idle_edges: got %0d required %0d", got_q.size() - b, 0); end
  endtask

  task automatic test_continuous();
    int a36, alast, b, fb, n;
    rand_img();
    cont_img = img;
    build_exp();
    b = got_q.size(); fb = fd_cnt;
    drive_range(0, NPIX - 1, 0, a36, alast);
    // keep offering sof pixels through DRAIN; they must be refused
    pix_sof = 1'b1; pix_valid = 1'b1; pix_in = 8'($urandom_range(255)); n = 0;
    while (pix_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    checks++; if (n != 3) begin failures++; $display("FAIL drain_ready_low: got %0d cycles required 3", n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_exit_busy: got %b required 0", busy); end
    repeat (10) @(negedge clock);
    checks++; if (got_q.size() - b != NEDGE) begin failures++; $display("FAIL cont_count: got %0d required %0d", got_q.size() - b, NEDGE); end
    for (int i = 0; i < NEDGE && b + i < got_q.size(); i++) begin
      cont_vals[i] = got_q[b+i];
      checks++; if (got_q[b+i] !== exp_q[i]) begin failures++; $display("FAIL cont_edge%0d: got %h required %h", i, got_q[b+i], exp_q[i]); end
    end
    if (got_q.size() > b) begin
      checks++; if (got_cyc[b] != a36 + 4) begin failures++; $display("FAIL first_edge_latency: got %0d required %0d", got_cyc[b] - a36, 4); end
      checks++; if (fd_cyc != got_cyc[got_q.size()-1] + 1) begin failures++; $display("FAIL frame_done_timing: got cycle %0d required %0d", fd_cyc, got_cyc[got_q.size()-1] + 1); end
    end
    checks++; if (fd_cnt - fb != 1) begin failures++; $display("FAIL cont_frame_done: got %0d required 1", fd_cnt - fb); end
  endtask

  task automatic test_ramp();
    int a36, alast, b;
    logic [199:0] m;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = r * W + c;
    build_exp();
    b = got_q.size();
    drive_range(0, 36, 0, a36, alast);
    m = matrix_out;
    checks++; if (m[199:192] !== 8'd0)  begin failures++; $display("FAIL ramp_z0: got %0d required 0", m[199:192]); end
    checks++; if (m[167:160] !== 8'd4)  begin failures++; $display("FAIL ramp_z4: got %0d required 4", m[167:160]); end
    checks++; if (m[103:96]  !== 8'd18) begin failures++; $display("FAIL ramp_z12: got %0d required 18", m[103:96]); end
    checks++; if (m[39:32]   !== 8'd32) begin failures++; $display("FAIL ramp_z20: got %0d required 32", m[39:32]); end
    checks++; if (m[7:0]     !== 8'd36) begin failures++; $display("FAIL ramp_z24: got %0d required 36", m[7:0]); end
    drive_range(37, NPIX - 1, 0, a36, alast);
    pix_valid = 1'b0;
    repeat (12) @(negedge clock);
    checks++; if (got_q.size() - b != NEDGE) begin failures++; $display("FAIL ramp_count: got %0d required %0d", got_q.size() - b, NEDGE); end
    for (int i = 0; i < NEDGE && b + i < got_q.size(); i++) begin
      checks++; if (got_q[b+i] !== exp_q[i]) begin failures++; $display("FAIL ramp_edge%0d: got %h required %h", i, got_q[b+i], exp_q[i]); end
    end
  endtask

  task automatic test_gaps();
    int a36, alast, b, fb;
    img = cont_img;
    build_exp();
    b = got_q.size(); fb = fd_cnt;
    drive_range(0, NPIX - 1, 50, a36, alast);
    pix_valid = 1'b0;
    repeat (12) @(negedge clock);
    checks++; if (got_q.size() - b != NEDGE) begin failures++; $display("FAIL gap_count: got %0d required %0d", got_q.size() - b, NEDGE); end
    for (int i = 0; i < NEDGE && b + i < got_q.size(); i++) begin
      checks++; if (got_q[b+i] !== exp_q[i] || got_q[b+i] !== cont_vals[i]) begin failures++; $display("FAIL gap_edge%0d: got %h required %h", i, got_q[b+i], exp_q[i]); end
    end
    checks++; if (fd_cnt - fb != 1) begin failures++; $display("FAIL gap_frame_done: got %0d required 1", fd_cnt - fb); end
  endtask

  task automatic test_resync();
    int a36, alast, b, fb;
    rand_img();
    b = got_q.size(); fb = fd_cnt;
    drive_range(0, 3 * W + 1, 0, a36, alast);
    rand_img();
    build_exp();
    drive_range(0, NPIX - 1, 0, a36, alast);
    pix_valid = 1'b0;
    repeat (12) @(negedge clock);
    checks++; if (got_q.size() - b != NEDGE) begin failures++; $display("FAIL resync_count: got %0d required %0d", got_q.size() - b, NEDGE); end
    for (int i = 0; i < NEDGE && b + i < got_q.size(); i++) begin
      checks++; if (got_q[b+i] !== exp_q[i]) begin failures++; $display("FAIL resync_edge%0d: got %h required %h", i, got_q[b+i], exp_q[i]); end
    end
    checks++; if (fd_cnt - fb != 1) begin failures++; $display("FAIL resync_frame_done: got %0d required 1", fd_cnt - fb); end
  endtask

  task automatic test_reset_midframe();
    int a36, alast, b, fb;
    rand_img();
    b = got_q.size(); fb = fd_cnt;
    drive_range(0, 37, 0, a36, alast);
    pix_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++; if (edge_out !== 8'hff) begin failures++; $display("FAIL midrst_edge_out: got %h required ff", edge_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (matrix_out !== 200'd0) begin failures++; $display("FAIL midrst_matrix: got %h required 0", matrix_out); end
    reset = 1'b0;
    repeat (12) @(negedge clock);
    checks++; if (got_q.size() != b) begin failures++; $display("FAIL midrst_edges: got %0d required 0", got_q.size() - b); end
    checks++; if (fd_cnt != fb) begin failures++; $display("FAIL midrst_frame_done: got %0d required 0", fd_cnt - fb); end
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b required 1", pix_ready); end
  endtask

  initial begin
    test_reset();
    test_idle_discard();
    test_continuous();
    test_ramp();
    test_gaps();
    test_resync();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
